// File: rtl/switch_pkg.sv
// Shared types and default sizing for the switch port receive path.
package switch_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. rd_data is a register that
// always shows the oldest entry and holds its last value when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [LW-1:0]         count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty      = (count == '0);
  assign full       = (count == LW'(DEPTH));
  assign level      = count;
  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // Storage array; no reset needed since rd_data is tracked separately.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue register: load the new head, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (empty && do_wr) begin
      rd_data <= wr_data;
    end else if (do_rd && count > LW'(1)) begin
      rd_data <= mem[rd_ptr_nxt];
    end else if (do_rd && do_wr) begin
      rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/switch_port_rx.sv
// Receive side of a switch port: four-phase-style req/ack capture into a
// packet FIFO. Optional packet counter enabled by SWITCH_PORT_RX_PKT_CNT_EN.
//
// state    | meaning
// IDLE     | waiting for port_req; captures when FIFO not full
// ACK      | port_received pulse for one cycle
// WAIT_LOW | waiting for the switch to drop port_req
module switch_port_rx
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          port_req,
  input  logic [DATA_WIDTH-1:0]         port_data,
  output logic                          port_received,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
  ,output logic [15:0]                  pkt_count
`endif
);

  rx_state_t state, state_nxt;
  logic      fifo_wr;
  logic      fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; full is the registered pre-edge value.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (port_req && !full) state_nxt = ACK;
      ACK:      state_nxt = port_req ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!port_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs: capture strobe in IDLE, acknowledge while in ACK.
  always_comb begin
    fifo_wr       = 1'b0;
    port_received = 1'b0;
    case (state)
      IDLE:    fifo_wr = port_req && !full;
      ACK:     port_received = 1'b1;
      default: ;
    endcase
  end

  assign rd_valid = !fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (port_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (full),
    .level   (level)
  );

`ifdef SWITCH_PORT_RX_PKT_CNT_EN
  logic [15:0] pkt_count_q;

  // Captured-packet counter, wraps at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pkt_count_q <= '0;
    else if (fifo_wr) pkt_count_q <= pkt_count_q + 16'd1;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Self-checking bench for switch_port_rx with a scoreboard of expected packets.
module tb_switch_port_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       port_req;
  logic [7:0] port_data;
  logic       port_received;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [2:0] level;
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
  logic [15:0] pkt_count;
  int          exp_cnt = 0;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  switch_port_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_req      (port_req),
    .port_data     (port_data),
    .port_received (port_received),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .level         (level)
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    ,.pkt_count    (pkt_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full handshake for one packet that is expected to be accepted at once.
  task automatic send_pkt(input logic [7:0] d);
    port_req  = 1'b1;
    port_data = d;
    tick();
    check_eq("ack_latency", {31'd0, port_received}, 32'd1);
    sb.push_back(d);
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    exp_cnt++;
`endif
    port_req  = 1'b0;
    port_data = 8'($urandom);
    tick();
    check_eq("ack_width", {31'd0, port_received}, 32'd0);
  endtask

  // Pop one entry and compare it against the scoreboard head.
  task automatic pop_chk;
    logic [7:0] exp;
    check_eq("pop_valid", {31'd0, rd_valid}, 32'd1);
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check_eq("pop_data", {24'd0, rd_data}, {24'd0, exp});
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain;
    int guard = 0;
    while (sb.size() != 0 && guard < 16) begin
      pop_chk();
      guard++;
    end
    check_eq("drain_level", {29'd0, level}, 32'd0);
    check_eq("drain_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset     = 1'b0;
    port_req  = 1'b0;
    port_data = 8'h00;
    rd_en     = 1'b0;
    #3;
    check_eq("rst_received", {31'd0, port_received}, 32'd0);
    check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_level", {29'd0, level}, 32'd0);
    check_eq("rst_data", {24'd0, rd_data}, 32'd0);
    #14;
    reset = 1'b1;
    tick();

    // Single packet.
    send_pkt(8'h45);
    check_eq("single_level", {29'd0, level}, 32'd1);
    check_eq("single_data", {24'd0, rd_data}, 32'h45);
    pop_chk();
    check_eq("empty_hold", {24'd0, rd_data}, 32'h45);
    check_eq("empty_level", {29'd0, level}, 32'd0);

    // Pop while empty is ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("empty_pop_level", {29'd0, level}, 32'd0);

    // Held request: one capture, one pulse.
    port_req  = 1'b1;
    port_data = 8'h45;
    pulses    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (port_received) pulses++;
    end
    port_req = 1'b0;
    tick();
    if (port_received) pulses++;
    tick();
    sb.push_back(8'h45);
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    exp_cnt++;
`endif
    check_eq("held_pulses", pulses, 32'd1);
    check_eq("held_level", {29'd0, level}, 32'd1);
    drain();

    // Overflow: fifth packet stalls until a pop, then is taken one edge later.
    for (int i = 1; i <= 4; i++) send_pkt(8'(i));
    check_eq("ovf_full", {31'd0, full}, 32'd1);
    check_eq("ovf_level", {29'd0, level}, 32'd4);
    port_req  = 1'b1;
    port_data = 8'h05;
    pulses    = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (port_received) pulses++;
    end
    check_eq("ovf_no_ack", pulses, 32'd0);
    pop_chk();
    check_eq("ovf_same_edge", {31'd0, port_received}, 32'd0);
    tick();
    check_eq("ovf_late_ack", {31'd0, port_received}, 32'd1);
    sb.push_back(8'h05);
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    exp_cnt++;
`endif
    port_req = 1'b0;
    tick();
    check_eq("ovf_refill", {29'd0, level}, 32'd4);
    drain();

    // Concurrent capture and pop.
    send_pkt(8'h11);
    send_pkt(8'h22);
    check_eq("conc_pre_level", {29'd0, level}, 32'd2);
    port_req  = 1'b1;
    port_data = 8'hAA;
    pop_chk();
    check_eq("conc_ack", {31'd0, port_received}, 32'd1);
    check_eq("conc_level", {29'd0, level}, 32'd2);
    sb.push_back(8'hAA);
`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    exp_cnt++;
`endif
    port_req = 1'b0;
    tick();
    drain();

    // Random packets with interleaved pops.
    for (int i = 0; i < 8; i++) begin
      send_pkt(8'($urandom));
      if ($urandom_range(0, 1) == 1) pop_chk();
    end
    drain();

`ifdef SWITCH_PORT_RX_PKT_CNT_EN
    check_eq("pkt_count", {16'd0, pkt_count}, exp_cnt);
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    send_pkt(8'h5A);
    check_eq("pkt_wrap", {16'd0, pkt_count}, 32'd0);
    drain();
`endif

    // Reset during ACK aborts; held request is recaptured afterwards.
    port_req  = 1'b1;
    port_data = 8'h77;
    tick();
    check_eq("rst_mid_ack", {31'd0, port_received}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_received", {31'd0, port_received}, 32'd0);
    check_eq("rst_mid_level", {29'd0, level}, 32'd0);
    check_eq("rst_mid_data", {24'd0, rd_data}, 32'd0);
    sb.delete();
    #2;
    reset = 1'b1;
    tick();
    check_eq("recapture_ack", {31'd0, port_received}, 32'd1);
    check_eq("recapture_level", {29'd0, level}, 32'd1);
    sb.push_back(8'h77);
    port_req = 1'b0;
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
